// File: rtl/fft_frame_serializer_pkg.sv
// Shared constants, state encoding and lane-index helper for the 32-point FFT output path.
package fft_pkg;

  localparam int N_PT  = 32;
  localparam int LOG2N = 5;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_PT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) begin
      r[b] = x[4-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Frame-in / sample-out handshake bundle; slave is the serializer, master is the driver and sink.
interface fft_frame_serializer_if #(
  parameter int W = 9
);
  import fft_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] d_r [N_PT];
  logic signed [W-1:0] d_i [N_PT];
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] q_r;
  logic signed [W-1:0] q_i;
  logic [LOG2N-1:0]    q_idx;
  logic                q_last;

  modport slave (
    input  in_valid, d_r, d_i, out_ready,
    output in_ready, out_valid, q_r, q_i, q_idx, q_last
  );

  modport master (
    output in_valid, d_r, d_i, out_ready,
    input  in_ready, out_valid, q_r, q_i, q_idx, q_last
  );

endinterface

// File: rtl/fft_frame_serializer_lane_mux.sv
// 32:1 read mux over the frame buffer, with optional bit-reversed lane selection.
module fft_lane_mux
  import fft_pkg::*;
#(
  parameter int W      = 9,
  parameter bit BITREV = 1'b0
) (
  input  logic signed [W-1:0] i_lane_r [N_PT],
  input  logic signed [W-1:0] i_lane_i [N_PT],
  input  logic [LOG2N-1:0]    i_sel,
  output logic signed [W-1:0] o_q_r,
  output logic signed [W-1:0] o_q_i
);

  logic [LOG2N-1:0] w_lane;

  assign w_lane = BITREV ? bitrev5(i_sel) : i_sel;
  assign o_q_r  = i_lane_r[w_lane];
  assign o_q_i  = i_lane_i[w_lane];

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures a whole 32-lane complex frame in one handshake and streams it out one sample per cycle.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int W      = 9,
  parameter bit BITREV = 1'b0
) (
  input logic                  clk,
  input logic                  rstb,
  fft_frame_serializer_if.slave bus
);

  state_t              r_state;
  state_t              w_state_next;
  logic [LOG2N-1:0]    r_cnt;
  logic [LOG2N-1:0]    w_cnt_next;
  logic signed [W-1:0] r_buf_r [N_PT];
  logic signed [W-1:0] r_buf_i [N_PT];

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_xfer;
  logic w_at_last;

  assign w_at_last   = (r_cnt == CNT_LAST);
  assign w_out_valid = (r_state == SEND);
  // Ready during the last beat lets the next frame load with no bubble.
  assign w_in_ready  = rstb && ((r_state == IDLE) ||
                                ((r_state == SEND) && w_at_last && bus.out_ready));
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_xfer      = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_accept) begin
      w_state_next = SEND;
      w_cnt_next   = '0;
    end else if (w_xfer) begin
      // Counter wraps to 0 on the last beat, so IDLE always sits at index 0.
      w_cnt_next = r_cnt + 1'b1;
      if (w_at_last) begin
        w_state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < N_PT; n++) begin
      if (!rstb) begin
        r_buf_r[n] <= '0;
        r_buf_i[n] <= '0;
      end else if (w_accept) begin
        r_buf_r[n] <= bus.d_r[n];
        r_buf_i[n] <= bus.d_i[n];
      end
    end
  end

  fft_lane_mux #(
    .W      (W),
    .BITREV (BITREV)
  ) u_lane_mux (
    .i_lane_r (r_buf_r),
    .i_lane_i (r_buf_i),
    .i_sel    (r_cnt),
    .o_q_r    (bus.q_r),
    .o_q_i    (bus.q_i)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.q_idx     = r_cnt;
  assign bus.q_last    = w_out_valid && w_at_last;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench: natural and bit-reversed instances driven in lockstep from one stimulus.
module tb_fft_frame_serializer;
  import fft_pkg::*;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] d_r [N_PT];
  logic signed [W-1:0] d_i [N_PT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_frame_serializer_if #(.W(W)) if0 ();
  fft_frame_serializer_if #(.W(W)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if1.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign if0.d_r = d_r;
  assign if1.d_r = d_r;
  assign if0.d_i = d_i;
  assign if1.d_i = d_i;

  fft_frame_serializer #(.W(W), .BITREV(1'b0)) dut0 (.clk(clk), .rstb(rstb), .bus(if0.slave));
  fft_frame_serializer #(.W(W), .BITREV(1'b1)) dut1 (.clk(clk), .rstb(rstb), .bus(if1.slave));

  typedef struct {
    int exp_r0;
    int exp_i0;
    int exp_r1;
    int exp_i1;
    int exp_last;
    int exp_in_ready;
  } beat_t;

  beat_t tbl [N_PT];

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) begin
      if (((k >> b) & 1) != 0) r = r | (1 << (4 - b));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_ramp(input int base);
    for (int n = 0; n < N_PT; n++) begin
      d_r[n] = W'(base + n);
      d_i[n] = W'(-(base + n));
    end
  endtask

  task automatic check_beat(input string tag, input int k,
                            input int er0, input int ei0, input int er1, input int ei1);
    chk($sformatf("%s_valid_k%0d", tag, k), {31'd0, if0.out_valid}, 1);
    chk($sformatf("%s_idx_k%0d", tag, k), {27'd0, if0.q_idx}, k);
    chk($sformatf("%s_idx1_k%0d", tag, k), {27'd0, if1.q_idx}, k);
    chk($sformatf("%s_last_k%0d", tag, k), {31'd0, if0.q_last}, (k == 31) ? 1 : 0);
    chk($sformatf("%s_qr0_k%0d", tag, k), 32'(if0.q_r), er0);
    chk($sformatf("%s_qi0_k%0d", tag, k), 32'(if0.q_i), ei0);
    chk($sformatf("%s_qr1_k%0d", tag, k), 32'(if1.q_r), er1);
    chk($sformatf("%s_qi1_k%0d", tag, k), 32'(if1.q_i), ei1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ovalid0"}, {31'd0, if0.out_valid}, 0);
    chk({tag, "_ovalid1"}, {31'd0, if1.out_valid}, 0);
    chk({tag, "_qr0"}, 32'(if0.q_r), 0);
    chk({tag, "_qi0"}, 32'(if0.q_i), 0);
    chk({tag, "_qr1"}, 32'(if1.q_r), 0);
    chk({tag, "_qidx"}, {27'd0, if0.q_idx}, 0);
    chk({tag, "_qlast"}, {31'd0, if0.q_last}, 0);
  endtask

  initial begin
    int exp_k;
    int c;

    for (int k = 0; k < N_PT; k++) begin
      tbl[k].exp_r0       = k;
      tbl[k].exp_i0       = -k;
      tbl[k].exp_r1       = rev5(k);
      tbl[k].exp_i1       = -rev5(k);
      tbl[k].exp_last     = (k == 31) ? 1 : 0;
      tbl[k].exp_in_ready = (k == 31) ? 1 : 0;
    end
    load_ramp(0);

    // Reset
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, if0.in_ready}, 0);
    check_quiet("rst");
    rstb = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, if0.in_ready}, 1);
    chk("post_rst_out_valid", {31'd0, if0.out_valid}, 0);

    // Single frame, natural and bit-reversed orders
    send_frame();
    for (int k = 0; k < N_PT; k++) begin
      check_beat("f1", k, tbl[k].exp_r0, tbl[k].exp_i0, tbl[k].exp_r1, tbl[k].exp_i1);
      chk($sformatf("f1_in_ready_k%0d", k), {31'd0, if0.in_ready}, tbl[k].exp_in_ready);
      chk($sformatf("f1_last1_k%0d", k), {31'd0, if1.q_last}, tbl[k].exp_last);
      if (k == 1) chk("f1_bitrev_k1", 32'(if1.q_r), 16);
      if (k == 2) chk("f1_bitrev_k2", 32'(if1.q_r), 8);
      if (k == 3) chk("f1_bitrev_k3", 32'(if1.q_r), 24);
      if (k == 4) chk("f1_bitrev_k4", 32'(if1.q_r), 4);
      tick();
    end
    chk("f1_end_out_valid", {31'd0, if0.out_valid}, 0);
    chk("f1_end_in_ready", {31'd0, if0.in_ready}, 1);

    // Back-to-back frames with in_valid held high
    load_ramp(0);
    in_valid = 1'b1;
    tick();
    load_ramp(100);
    for (int k = 0; k < N_PT; k++) begin
      check_beat("b2b_a", k, k, -k, rev5(k), -rev5(k));
      chk($sformatf("b2b_in_ready_k%0d", k), {31'd0, if0.in_ready}, (k == 31) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < N_PT; k++) begin
      check_beat("b2b_b", k, 100 + k, -(100 + k), 100 + rev5(k), -(100 + rev5(k)));
      tick();
    end
    chk("b2b_end_out_valid", {31'd0, if0.out_valid}, 0);

    // Backpressure on cycles 5..9; inputs scrambled after accept must not matter
    load_ramp(0);
    send_frame();
    for (int n = 0; n < N_PT; n++) begin
      d_r[n] = W'(77);
      d_i[n] = W'(-77);
    end
    exp_k = 0;
    c = 0;
    while (exp_k < N_PT && c < 60) begin
      out_ready = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      #1;
      check_beat("bp", exp_k, exp_k, -exp_k, rev5(exp_k), -rev5(exp_k));
      chk($sformatf("bp_in_ready_c%0d", c), {31'd0, if0.in_ready},
          (exp_k == 31 && out_ready) ? 1 : 0);
      tick();
      if (out_ready) exp_k++;
      c++;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_beats_done", exp_k, N_PT);
    chk("bp_end_out_valid", {31'd0, if0.out_valid}, 0);

    // Mid-frame reset at beat 10
    load_ramp(0);
    send_frame();
    for (int k = 0; k < 10; k++) tick();
    check_beat("mr_pre", 10, 10, -10, rev5(10), -rev5(10));
    rstb = 1'b0;
    #1;
    chk("mr_in_ready_low", {31'd0, if0.in_ready}, 0);
    tick();
    check_quiet("mr");
    rstb = 1'b1;
    #1;
    chk("mr_rel_in_ready", {31'd0, if0.in_ready}, 1);
    chk("mr_rel_out_valid", {31'd0, if0.out_valid}, 0);
    load_ramp(50);
    send_frame();
    for (int k = 0; k < N_PT; k++) begin
      check_beat("mr_new", k, 50 + k, -(50 + k), 50 + rev5(k), -(50 + rev5(k)));
      tick();
    end
    chk("mr_end_out_valid", {31'd0, if0.out_valid}, 0);

    // Signed extremes
    for (int n = 0; n < N_PT; n++) begin
      d_r[n] = ((n % 2) == 0) ? W'(-256) : W'(255);
      d_i[n] = ((n % 2) == 0) ? W'(255) : W'(-256);
    end
    send_frame();
    for (int k = 0; k < N_PT; k++) begin
      check_beat("ext", k,
                 ((k % 2) == 0) ? -256 : 255, ((k % 2) == 0) ? 255 : -256,
                 ((rev5(k) % 2) == 0) ? -256 : 255, ((rev5(k) % 2) == 0) ? 255 : -256);
      tick();
    end
    chk("ext_end_out_valid", {31'd0, if0.out_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
